// File: rtl/siso_tx_ctrl.sv
// Serialises parallel words MSB-first into a DW-deep left-shifting SISO register,
// then flushes DW zeros so every data bit reaches the register output.
module siso_tx_ctrl #(
   parameter int DW = 4,
   parameter int WW = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick,
   input  logic [WW-1:0]                 in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          shift_enb,
   output logic                          shift_inp,
   output logic                          out_vld,
   output logic [$clog2(WW+DW+1)-1:0]    bit_idx,
   output logic                          busy,
   output logic                          done,
   output logic [1:0]                    dbg_state
);

   localparam int BW = $clog2(WW+DW+1);
   localparam logic [BW-1:0] LAST_DATA  = BW'(WW-1);
   localparam logic [BW-1:0] LAST_SHIFT = BW'(WW+DW-1);
   localparam logic [BW-1:0] VLD_ON     = BW'(DW-1);

   // Handshake: a word transfers on a rising clk edge where in_valid && in_ready
   // (and rst is low); the producer holds in_data/in_valid stable until then.
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FLUSH = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   hold_q, hold_d;
   logic [BW-1:0]   idx_q, idx_d;
   logic            done_q, done_d;
   logic            vld_q, vld_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
      end
   end

   // The hold register shifts left with each data shift, so its MSB is always the next bit.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      vld_d     = vld_q;
      in_ready  = 1'b0;
      shift_enb = 1'b0;
      shift_inp = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_d  = in_data;
               idx_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_enb = tick;
            shift_inp = hold_q[WW-1];
            if (tick) begin
               hold_d = hold_q << 1;
               idx_d  = idx_q + 1'b1;
               if (idx_q == LAST_DATA) state_d = FLUSH;
            end
         end
         FLUSH: begin
            shift_enb = tick;
            if (tick) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_SHIFT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Register output carries data from shift DW up to (not after) shift WW+DW.
      if (shift_enb) begin
         if (idx_q == VLD_ON)          vld_d = 1'b1;
         else if (idx_q == LAST_SHIFT) vld_d = 1'b0;
      end
   end

   assign busy      = (state_q != IDLE);
   assign bit_idx   = idx_q;
   assign done      = done_q;
   assign out_vld   = vld_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Randomised bench for siso_tx_ctrl: a word-level reference model plus a model of
// the downstream SISO register and serial sink.
module tb_siso_tx_ctrl;

   localparam int WW = 8;
   localparam int DW = 4;
   localparam int BW = $clog2(WW+DW+1);

   logic          clk = 1'b0;
   logic          rst, tick, in_valid;
   logic [WW-1:0] in_data;
   logic          in_ready, shift_enb, shift_inp, out_vld, busy, done;
   logic [BW-1:0] bit_idx;
   logic [1:0]    dbg_state;

   siso_tx_ctrl #(.DW(DW), .WW(WW)) dut (
      .clk(clk), .rst(rst), .tick(tick), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .shift_enb(shift_enb), .shift_inp(shift_inp),
      .out_vld(out_vld), .bit_idx(bit_idx), .busy(busy), .done(done),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- tick generator ----------------
   int tick_mode = 0;
   int cyc = 0;
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (tick_mode)
            0:       tick = 1'b1;
            1:       tick = (cyc % 3 == 0);
            default: tick = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [WW-1:0]    exp_q[$];
   bit               mon_en = 0;
   bit               m_active = 0;
   int               m_n = 0;
   bit               m_done = 0;
   logic [WW+DW-1:0] m_seq;
   logic [DW-1:0]    reg_m = '0;
   int               sh_cnt = 0;
   int               done_cnt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("in_ready", 32'(in_ready), 32'(!m_active));
         check_eq("busy", 32'(busy), 32'(m_active));
         check_eq("dbg_idle", 32'(dbg_state == 2'd0), 32'(!m_active));
         check_eq("shift_enb", 32'(shift_enb), 32'(tick && m_active));
         check_eq("shift_inp", 32'(shift_inp), 32'(m_active ? m_seq[m_n] : 1'b0));
         check_eq("out_vld", 32'(out_vld), 32'(m_active && m_n >= DW));
         check_eq("bit_idx", 32'(bit_idx), 32'(m_n));
         check_eq("done", 32'(done), 32'(m_done));

         // sink samples the register output before this tick's shift
         if (tick && out_vld) begin
            if (exp_q.size() == 0) check_eq("rx_extra", 32'(out_vld), 32'(0));
            else                   check_eq("rx_bit", 32'(reg_m[DW-1]), 32'(exp_q.pop_front()));
         end
         if (shift_enb) begin
            reg_m = {reg_m[DW-2:0], shift_inp};
            sh_cnt++;
         end
         if (done) begin
            check_eq("shifts_per_word", 32'(sh_cnt), 32'(WW+DW));
            done_cnt++;
         end

         // model update for the coming edge
         if (rst) begin
            m_active = 0;
            m_n      = 0;
            m_done   = 0;
            sh_cnt   = 0;
            exp_q.delete();
         end else begin
            m_done = 0;
            if (!m_active) begin
               if (in_valid) begin
                  m_active = 1;
                  m_n      = 0;
                  sh_cnt   = 0;
                  m_seq    = '0;
                  for (int i = 0; i < WW; i++) m_seq[i] = in_data[WW-1-i];
                  for (int i = WW-1; i >= 0; i--) exp_q.push_back(in_data[i]);
               end
            end else if (tick) begin
               m_n++;
               if (m_n == WW+DW) begin
                  m_active = 0;
                  m_done   = 1;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [WW-1:0] w, output bit acc_done);
      int k;
      in_valid = 1'b1;
      in_data  = w;
      acc_done = 0;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (k == 400) check_eq("accept_timeout", 32'(in_ready), 32'(1));
      acc_done = done;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit toggle);
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!busy) break;
         @(posedge clk);
         #1;
         if (toggle) in_data = WW'($urandom);
      end
      if (k == 400) check_eq("idle_timeout", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   int words_done_exp = 0;
   bit d;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk);
      #1;
      mon_en = 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'(1));
      check_eq("rst_bit_idx", 32'(bit_idx), 32'(0));
      check_eq("rst_done", 32'(done), 32'(0));
      @(posedge clk);
      #1;

      // continuous ticks, 0xA5
      tick_mode = 0;
      send_word(8'hA5, d); wait_idle(0); words_done_exp++;

      // tick every third cycle, 0xFF
      tick_mode = 1;
      send_word(8'hFF, d); wait_idle(0); words_done_exp++;

      // back-to-back 0x81 then 0x3C
      tick_mode = 0;
      send_word(8'h81, d);
      send_word(8'h3C, d);
      check_eq("b2b_accept_in_done", 32'(d), 32'(1));
      wait_idle(0); words_done_exp += 2;

      // reset in the cycle after shift 5 of 0x5A, then 0x0F
      send_word(8'h5A, d);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bit_idx == BW'(4)) break;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_in_ready", 32'(in_ready), 32'(1));
      check_eq("abort_bit_idx", 32'(bit_idx), 32'(0));
      check_eq("abort_out_vld", 32'(out_vld), 32'(0));
      @(posedge clk);
      #1;
      send_word(8'h0F, d); wait_idle(0); words_done_exp++;

      // in_data toggled while busy, random ticks
      tick_mode = 2;
      send_word(8'hC3, d); wait_idle(1); words_done_exp++;

      // randomised words, gaps, tick patterns and back-to-back runs
      for (int n = 0; n < 30; n++) begin
         tick_mode = $urandom_range(0, 2);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send_word(WW'($urandom), d);
         words_done_exp++;
         if ($urandom_range(0, 2) != 0) wait_idle($urandom_range(0, 1) == 1);
      end
      wait_idle(0);
      repeat (2) @(posedge clk);
      #1;

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'(0));
      check_eq("words_done", 32'(done_cnt), 32'(words_done_exp));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
